// File: rtl/pp_buf_pkg.sv
// ---------------------------------------------------------------------------
// pp_buf_pkg
// Shared definitions for the ping-pong window buffer:
//   - bit positions inside the sticky err vector
//   - slice helper for the packed per-port rd_addr / rd_data buses
// ---------------------------------------------------------------------------
package pp_buf_pkg;

   localparam int ERR_BAD_WRITE  = 0;
   localparam int ERR_BAD_COMMIT = 1;
   localparam int ERR_ADDR_OOB   = 2;

   // LSB position of port 'port' inside a packed bus of 'width'-bit fields
   function automatic int slice_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// ---------------------------------------------------------------------------
// pp_bank_ram
// Simple dual-port RAM holding both banks of one read port's copy.
// One write port, one registered read port (1-cycle latency).
// Ports:
//   clk, rst_n      clock, async active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request; rdata updates only when re=1
//   rdata           registered read data, holds between reads
// ---------------------------------------------------------------------------
module pp_bank_ram #(
   parameter int DATA_W = 8,
   parameter int WORDS  = 2048,
   parameter int AW     = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [WORDS];

   // Storage array has no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value when no read is requested
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/pingpong_window_buf.sv
// ---------------------------------------------------------------------------
// pingpong_window_buf
// Double-buffered window store: one writer fills a bank while NUM_RD read
// ports consume the other. Banks change owner explicitly: wr_commit hands a
// filled bank to the reader, rd_release hands a consumed bank back.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_en/wr_addr/wr_data write into the current write bank
//   wr_commit             mark current write bank full and move to the other
//   wr_ready              current write bank is free
//   rd_en/rd_addr         read all ports from the current read bank
//   rd_data/rd_valid      read result, RD_LAT cycles after rd_en
//   rd_release            free the current read bank
//   rd_ready              current read bank holds committed data
//   occupancy             number of committed, unreleased banks
//   err                   sticky {addr_oob, bad_commit, bad_write}
// ---------------------------------------------------------------------------
module pingpong_window_buf
   import pp_buf_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int NUM_RD = 25,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_commit,
   output logic                     wr_ready,
   input  logic                     rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     rd_valid,
   input  logic                     rd_release,
   output logic                     rd_ready,
   output logic [1:0]               occupancy,
   output logic [2:0]               err
);

   localparam int PA_W = $clog2(2 * DEPTH);

   logic                     wr_bank;
   logic                     rd_bank;
   logic [1:0]               full;
   logic [2:0]               err_q;
   logic                     wr_in_range;
   logic                     wr_do;
   logic                     commit_ok;
   logic                     release_ok;
   logic                     rd_fire;
   logic [PA_W-1:0]          wr_pa;
   logic [PA_W-1:0]          rd_base;
   logic [NUM_RD-1:0]        port_oob;
   logic [NUM_RD*DATA_W-1:0] ram_bus;
   logic [RD_LAT-1:0]        valid_pipe;

   assign wr_ready   = ~full[wr_bank];
   assign rd_ready   = full[rd_bank];
   assign occupancy  = {1'b0, full[0]} + {1'b0, full[1]};
   assign err        = err_q;

   assign wr_in_range = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
   assign wr_do       = wr_en & wr_ready & wr_in_range;
   assign commit_ok   = wr_commit & wr_ready;
   assign release_ok  = rd_release & rd_ready;
   assign rd_fire     = rd_en & rd_ready;

   assign wr_pa   = (wr_bank ? PA_W'(DEPTH) : '0) + PA_W'(wr_addr);
   assign rd_base = rd_bank ? PA_W'(DEPTH) : '0;

   // Bank ownership and sticky errors. A commit and a release in the same
   // cycle always touch different banks (one is free, the other full), so
   // both updates can be applied independently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         err_q   <= '0;
      end else begin
         if (commit_ok) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
         end
         if (release_ok) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
         if (wr_en && !wr_ready) begin
            err_q[ERR_BAD_WRITE] <= 1'b1;
         end
         if (wr_commit && !wr_ready) begin
            err_q[ERR_BAD_COMMIT] <= 1'b1;
         end
         if ((wr_en && !wr_in_range) || (rd_fire && (|port_oob))) begin
            err_q[ERR_ADDR_OOB] <= 1'b1;
         end
      end
   end

   // One RAM copy per read port; writes broadcast to every copy
   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic [PA_W-1:0]   pa;
      logic [DATA_W-1:0] q;
      logic              oob_q;

      assign addr        = rd_addr[slice_lsb(i, ADDR_W) +: ADDR_W];
      assign port_oob[i] = ~({1'b0, addr} < (ADDR_W+1)'(DEPTH));
      // Out-of-range ports read the bank base instead of running off the array
      assign pa          = port_oob[i] ? rd_base : rd_base + PA_W'(addr);

      pp_bank_ram #(
         .DATA_W (DATA_W),
         .WORDS  (2 * DEPTH),
         .AW     (PA_W)
      ) u_ram (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (wr_do),
         .waddr (wr_pa),
         .wdata (wr_data),
         .re    (rd_fire),
         .raddr (pa),
         .rdata (q)
      );

      // Remember which reads were out of range so they come back as zero
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            oob_q <= 1'b0;
         end else if (rd_fire) begin
            oob_q <= port_oob[i];
         end
      end

      assign ram_bus[slice_lsb(i, DATA_W) +: DATA_W] = oob_q ? '0 : q;
   end

   // Valid follows the accepted read through RD_LAT stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_pipe <= '0;
      end else begin
         valid_pipe[0] <= rd_fire;
         for (int k = 1; k < RD_LAT; k++) begin
            valid_pipe[k] <= valid_pipe[k-1];
         end
      end
   end

   assign rd_valid = valid_pipe[RD_LAT-1];

   // Extra output registers beyond the RAM's own read register. They shift
   // every cycle; since the RAM register holds between reads, rd_data still
   // settles on the most recent read result.
   if (RD_LAT > 1) begin : g_out
      logic [NUM_RD*DATA_W-1:0] stage [RD_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < RD_LAT-1; k++) begin
               stage[k] <= '0;
            end
         end else begin
            stage[0] <= ram_bus;
            for (int k = 1; k < RD_LAT-1; k++) begin
               stage[k] <= stage[k-1];
            end
         end
      end

      assign rd_data = stage[RD_LAT-2];
   end else begin : g_direct
      assign rd_data = ram_bus;
   end

endmodule

// File: tb/tb_pingpong_window_buf.sv
// ---------------------------------------------------------------------------
// tb_pingpong_window_buf
// Directed bench for pingpong_window_buf. DEPTH is deliberately not a power
// of two so out-of-range addresses are representable; RD_LAT=3 exercises the
// extra output stages. Control sequences come from a vector table, read
// traffic from hand-written loops with a small delay-line expectation model.
// ---------------------------------------------------------------------------
module tb_pingpong_window_buf;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 200;
   localparam int NUM_RD = 25;
   localparam int ADDR_W = 8;
   localparam int RD_LAT = 3;
   localparam int AB     = NUM_RD * ADDR_W;
   localparam int BW     = NUM_RD * DATA_W;

   logic              clk;
   logic              rst_n;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_commit;
   logic              wr_ready;
   logic              rd_en;
   logic [AB-1:0]     rd_addr;
   logic [BW-1:0]     rd_data;
   logic              rd_valid;
   logic              rd_release;
   logic              rd_ready;
   logic [1:0]        occupancy;
   logic [2:0]        err;

   pingpong_window_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NUM_RD (NUM_RD),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_commit  (wr_commit),
      .wr_ready   (wr_ready),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_release (rd_release),
      .rd_ready   (rd_ready),
      .occupancy  (occupancy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        wr_en;
      logic [7:0]  wr_data;
      logic        commit;
      logic        rel;
      logic        exp_wr_ready;
      logic        exp_rd_ready;
      logic [1:0]  exp_occ;
      logic [2:0]  exp_err;
   } ctrl_vec_t;

   ctrl_vec_t     vecs [6];
   int            checks   = 0;
   int            failures = 0;
   logic          ev [RD_LAT];
   logic [BW-1:0] ed [RD_LAT];
   logic [BW-1:0] last_data;
   logic [AB-1:0] ra;
   logic [BW-1:0] eb;

   task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic resetModel();
      for (int k = 0; k < RD_LAT; k++) begin
         ev[k] = 1'b0;
         ed[k] = '0;
      end
      last_data = '0;
   endtask

   // Drive one cycle of inputs, clock it, then check the read outputs against
   // a delay line of what each accepted read should return RD_LAT cycles on.
   task automatic applyStimulus(input logic we, input int wa, input logic [7:0] wd, input logic cm,
                                input logic re, input logic [AB-1:0] rda, input logic rl,
                                input logic fire, input logic [BW-1:0] exp_bus);
      wr_en      = we;
      wr_addr    = ADDR_W'(wa);
      wr_data    = wd;
      wr_commit  = cm;
      rd_en      = re;
      rd_addr    = rda;
      rd_release = rl;
      @(posedge clk);
      #1;
      for (int k = RD_LAT-1; k > 0; k--) begin
         ev[k] = ev[k-1];
         ed[k] = ed[k-1];
      end
      ev[0] = fire;
      ed[0] = exp_bus;
      checkOutput("rd_valid", BW'(rd_valid), BW'(ev[RD_LAT-1]));
      if (ev[RD_LAT-1]) last_data = ed[RD_LAT-1];
      checkOutput("rd_data", rd_data, last_data);
   endtask

   task automatic applyVec(input int idx);
      applyStimulus(vecs[idx].wr_en, 0, vecs[idx].wr_data, vecs[idx].commit, 1'b0, '0,
                    vecs[idx].rel, 1'b0, '0);
      checkOutput({vecs[idx].name, ".wr_ready"}, BW'(wr_ready), BW'(vecs[idx].exp_wr_ready));
      checkOutput({vecs[idx].name, ".rd_ready"}, BW'(rd_ready), BW'(vecs[idx].exp_rd_ready));
      checkOutput({vecs[idx].name, ".occupancy"}, BW'(occupancy), BW'(vecs[idx].exp_occ));
      checkOutput({vecs[idx].name, ".err"}, BW'(err), BW'(vecs[idx].exp_err));
   endtask

   function automatic logic [7:0] data_of(input int mode, input int a);
      if (mode == 2) return 8'((a * 3 + 1) % 256);
      return 8'(a % 256);
   endfunction

   function automatic logic [AB-1:0] addr_bus(input int stride, input int offset);
      logic [AB-1:0] b;
      for (int i = 0; i < NUM_RD; i++) b[i*ADDR_W +: ADDR_W] = ADDR_W'((offset + stride * i) % DEPTH);
      return b;
   endfunction

   function automatic logic [BW-1:0] pat_bus(input int mode, input int stride, input int offset);
      logic [BW-1:0] b;
      for (int i = 0; i < NUM_RD; i++) b[i*DATA_W +: DATA_W] = data_of(mode, (offset + stride * i) % DEPTH);
      return b;
   endfunction

   function automatic logic [BW-1:0] const_bus(input logic [7:0] v);
      return {NUM_RD{v}};
   endfunction

   task automatic fillBank(input int mode, input logic [7:0] cval, input int start);
      for (int a = start; a < DEPTH; a++) begin
         applyStimulus(1'b1, a, (mode == 1) ? cval : data_of(mode, a), 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      //         name            we   data   cm   rel  wrdy rrdy occ    err
      vecs[0] = '{"fill_both",   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000};
      vecs[1] = '{"bad_write",   1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b001};
      vecs[2] = '{"bad_commit",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'b011};
      vecs[3] = '{"release0",    1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 3'b011};
      vecs[4] = '{"commit1",     1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 3'b011};
      vecs[5] = '{"commit_rel",  1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 3'b011};

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
      rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.wr_ready", BW'(wr_ready), BW'(1'b1));
      checkOutput("reset.rd_ready", BW'(rd_ready), BW'(1'b0));
      checkOutput("reset.rd_valid", BW'(rd_valid), BW'(1'b0));
      checkOutput("reset.rd_data", rd_data, '0);
      checkOutput("reset.occupancy", BW'(occupancy), BW'(2'd0));
      checkOutput("reset.err", BW'(err), BW'(3'b000));
      rst_n = 1'b1;

      $display("[TB] fill bank0 with address pattern and commit");
      fillBank(0, 8'h00, 0);
      applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("commit0.wr_ready", BW'(wr_ready), BW'(1'b1));
      checkOutput("commit0.rd_ready", BW'(rd_ready), BW'(1'b1));
      checkOutput("commit0.occupancy", BW'(occupancy), BW'(2'd1));

      $display("[TB] window read at 5*i");
      applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(5, 0), 1'b0, 1'b1, pat_bus(0, 5, 0));
      idle(RD_LAT);

      $display("[TB] fill bank1, overfill errors, readback");
      fillBank(1, 8'hAA, 0);
      for (int v = 0; v < 3; v++) applyVec(v);
      applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(5, 0), 1'b0, 1'b1, pat_bus(0, 5, 0));
      idle(RD_LAT);
      applyVec(3);

      $display("[TB] ping-pong stream");
      for (int c = 0; c < DEPTH; c++) begin
         applyStimulus(1'b1, c, 8'h55, 1'b0, 1'b1, addr_bus(1, c), 1'b0, 1'b1, const_bus(8'hAA));
      end
      applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b1, addr_bus(1, 3), 1'b0, 1'b1, const_bus(8'hAA));
      applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(1, 4), 1'b1, 1'b1, const_bus(8'hAA));
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(2, c), 1'b0, 1'b1, const_bus(8'h55));
      end
      applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(1, 9), 1'b1, 1'b1, const_bus(8'h55));
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(1, c), 1'b0, 1'b0, '0);
      end
      idle(RD_LAT);
      checkOutput("drained.occupancy", BW'(occupancy), BW'(2'd0));
      checkOutput("drained.rd_ready", BW'(rd_ready), BW'(1'b0));
      checkOutput("drained.wr_ready", BW'(wr_ready), BW'(1'b1));

      $display("[TB] same-cycle commit, release and write");
      fillBank(1, 8'h11, 0);
      applyVec(4);
      fillBank(2, 8'h00, 1);
      applyVec(5);

      $display("[TB] back-to-back burst and out-of-range port");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(1, k), 1'b0, 1'b1, pat_bus(2, 1, k));
      end
      ra = addr_bus(1, 10);
      ra[7*ADDR_W +: ADDR_W] = ADDR_W'(DEPTH);
      eb = pat_bus(2, 1, 10);
      eb[7*DATA_W +: DATA_W] = '0;
      applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, ra, 1'b0, 1'b1, eb);
      idle(RD_LAT);
      checkOutput("oob.err", BW'(err), BW'(3'b111));

      $display("[TB] asynchronous reset mid-burst");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1, addr_bus(1, 20 + k), 1'b0, 1'b1, pat_bus(2, 1, 20 + k));
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst.rd_valid", BW'(rd_valid), BW'(1'b0));
      checkOutput("async_rst.occupancy", BW'(occupancy), BW'(2'd0));
      checkOutput("async_rst.wr_ready", BW'(wr_ready), BW'(1'b1));
      checkOutput("async_rst.rd_ready", BW'(rd_ready), BW'(1'b0));
      checkOutput("async_rst.err", BW'(err), BW'(3'b000));
      checkOutput("async_rst.rd_data", rd_data, '0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("held_rst.rd_valid", BW'(rd_valid), BW'(1'b0));
      checkOutput("held_rst.occupancy", BW'(occupancy), BW'(2'd0));
      rd_en = 1'b0;
      rst_n = 1'b1;
      resetModel();
      idle(2);
      checkOutput("post_rst.rd_ready", BW'(rd_ready), BW'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
